// File: rtl/cpu_fsm_pkg.sv
// Shared encodings for the Lab 6 controller, decoder and datapath top level:
// opcode/op fields, nsel and vsel codes, and the one-hot state set.
package cpu_fsm_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op meanings depend on the opcode they accompany
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM8  = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    typedef enum logic [7:0] {
        S_WAIT   = 8'b0000_0001,
        S_DECODE = 8'b0000_0010,
        S_GETA   = 8'b0000_0100,
        S_GETB   = 8'b0000_1000,
        S_ALU    = 8'b0001_0000,
        S_CMP    = 8'b0010_0000,
        S_WREG   = 8'b0100_0000,
        S_WIMM   = 8'b1000_0000
    } state_t;

    // First micro-step after decode; S_WAIT marks an unsupported instruction.
    function automatic state_t decode_target(input logic [2:0] opc, input logic [1:0] op);
        state_t nxt;
        nxt = S_WAIT;
        if (opc == OPC_MOV) begin
            if (op == OP_MOV_IMM)      nxt = S_WIMM;
            else if (op == OP_MOV_REG) nxt = S_GETB;
        end else if (opc == OPC_ALU) begin
            if (op == OP_MVN) nxt = S_GETB;
            else              nxt = S_GETA;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_fsm.sv
// Moore sequencer for the Lab 6 datapath: one micro-step per clock, with
// outputs decoded only from the state register and the latched instruction.
module cpu_fsm
    import cpu_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_ir_opc;
    logic [1:0] r_ir_op;
    state_t     w_dec_target;
    logic       w_is_cmp;
    logic       w_zero_a;

    assign w_dec_target = decode_target(r_ir_opc, r_ir_op);
    assign w_is_cmp     = (r_ir_opc == OPC_ALU) && (r_ir_op == OP_CMP);
    assign w_zero_a     = ((r_ir_opc == OPC_MOV) && (r_ir_op == OP_MOV_REG)) ||
                          ((r_ir_opc == OPC_ALU) && (r_ir_op == OP_MVN));

    // NOTE: state and captured fields use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_WAIT;
            r_ir_opc <= '0;
            r_ir_op  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && s) begin
                r_ir_opc <= opcode;
                r_ir_op  <= op;
            end
        end
    end

    // NOTE: defaults come first so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_next = S_WAIT;
        case (r_state)
            S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
            S_DECODE: w_next = w_dec_target;
            S_GETA:   w_next = S_GETB;
            S_GETB:   w_next = w_is_cmp ? S_CMP : S_ALU;
            S_ALU:    w_next = S_WREG;
            S_CMP:    w_next = S_WAIT;
            S_WREG:   w_next = S_WAIT;
            S_WIMM:   w_next = S_WAIT;
            default:  w_next = S_WAIT;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        vsel    = VSEL_C;
        write   = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_WAIT:   w = 1'b1;
            S_DECODE: illegal = (w_dec_target == S_WAIT);
            S_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                loadc = 1'b1;
                asel  = w_zero_a;
            end
            S_CMP:    loads = 1'b1;
            S_WREG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_WIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_fsm.sv
// Scoreboard bench for cpu_fsm: each instruction pushes its expected per-cycle
// output vectors, which are popped and compared on every falling edge.
module tb_cpu_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, illegal;
    logic [2:0] nsel;
    logic [1:0] vsel;

    cpu_fsm dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .write(write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          wr_times[$];
    logic [13:0] exp_q[$];

    // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal}
    wire [13:0] dut_v = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal};

    function automatic logic [13:0] ov(input logic w_i, input logic [2:0] ns,
                                       input logic la, input logic lb, input logic lc,
                                       input logic ls, input logic as_i,
                                       input logic [1:0] vs, input logic wr, input logic il);
        return {w_i, ns, la, lb, lc, ls, as_i, 1'b0, vs, wr, il};
    endfunction

    logic [13:0] v_idle, v_dec, v_ill, v_geta, v_getb, v_alu0, v_alu1, v_cmp, v_wreg, v_wimm;
    initial begin
        v_idle = ov(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        v_dec  = ov(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        v_ill  = ov(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        v_geta = ov(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        v_getb = ov(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        v_alu0 = ov(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0);
        v_alu1 = ov(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0);
        v_cmp  = ov(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        v_wreg = ov(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        v_wimm = ov(0, 3'b100, 0, 0, 0, 0, 0, 2'b10, 1, 0);
    end

    // Write pulses, logged with the cycle number at the edge that ends them.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (write === 1'b1) wr_times.push_back(cyc);
    end

    task automatic push_expected(input logic [2:0] opc, input logic [1:0] o);
        case ({opc, o})
            5'b110_10: begin exp_q.push_back(v_dec); exp_q.push_back(v_wimm); end
            5'b110_00, 5'b101_11: begin
                exp_q.push_back(v_dec);  exp_q.push_back(v_getb);
                exp_q.push_back(v_alu1); exp_q.push_back(v_wreg);
            end
            5'b101_00, 5'b101_10: begin
                exp_q.push_back(v_dec);  exp_q.push_back(v_geta); exp_q.push_back(v_getb);
                exp_q.push_back(v_alu0); exp_q.push_back(v_wreg);
            end
            5'b101_01: begin
                exp_q.push_back(v_dec);  exp_q.push_back(v_geta);
                exp_q.push_back(v_getb); exp_q.push_back(v_cmp);
            end
            default: exp_q.push_back(v_ill);
        endcase
        exp_q.push_back(v_idle);
    endtask

    // Entered at a falling edge with the DUT idle; leaves at the falling edge where it is idle again.
    task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                             input int lat, input int n_wr, input bit hold_s, input bit mid_change);
        int edges;
        int first_w;
        int wr0;
        logic [13:0] e;
        edges   = 0;
        first_w = -1;
        wr0     = wr_times.size();
        s = 1'b1; opcode = opc; op = o;
        push_expected(opc, o);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            edges++;
            if (edges == 1 && !hold_s) s = 1'b0;
            if (mid_change && edges == 2) begin opcode = 3'b110; op = 2'b10; end
            e = exp_q.pop_front();
            n_tests++;
            if (dut_v !== e) begin
                n_fail++;
                $display("FAIL %s step %0d: got %b expected %b", name, edges, dut_v, e);
            end
            if (dut_v[13] === 1'b1 && first_w < 0) first_w = edges;
        end
        n_tests++;
        if (first_w !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges expected %0d", name, first_w, lat);
        end
        n_tests++;
        if (wr_times.size() - wr0 !== n_wr) begin
            n_fail++;
            $display("FAIL %s writes: got %0d expected %0d", name, wr_times.size() - wr0, n_wr);
        end
    endtask

    task automatic check_idle_cycles(input string name, input int n);
        logic [13:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v_idle);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (dut_v !== e) begin
                n_fail++;
                $display("FAIL %s idle %0d: got %b expected %b", name, i, dut_v, e);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; s = 1'b1; opcode = 3'b110; op = 2'b10;
        check_idle_cycles("reset_held", 2);
        reset = 1'b0; s = 1'b0;
        check_idle_cycles("after_reset", 2);
    endtask

    task automatic test_mov_imm;
        run_instr("mov_imm", 3'b110, 2'b10, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_add_and;
        run_instr("add_opchange", 3'b101, 2'b00, 6, 1, 1'b0, 1'b1);
        run_instr("and", 3'b101, 2'b10, 6, 1, 1'b0, 1'b0);
    endtask

    task automatic test_cmp_mvn;
        run_instr("cmp", 3'b101, 2'b01, 5, 0, 1'b0, 1'b0);
        run_instr("mvn", 3'b101, 2'b11, 5, 1, 1'b0, 1'b0);
        run_instr("mov_reg", 3'b110, 2'b00, 5, 1, 1'b0, 1'b0);
    endtask

    task automatic test_illegal;
        run_instr("illegal_000", 3'b000, 2'b00, 2, 0, 1'b0, 1'b0);
        run_instr("illegal_110_11", 3'b110, 2'b11, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_instr;
        logic [13:0] e;
        int wr0;
        wr0 = wr_times.size();
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        exp_q.push_back(v_dec); exp_q.push_back(v_geta); exp_q.push_back(v_getb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if (dut_v !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i + 1, dut_v, e);
            end
        end
        reset = 1'b1;
        check_idle_cycles("reset_mid_abort", 1);
        reset = 1'b0;
        check_idle_cycles("reset_mid_after", 3);
        n_tests++;
        if (wr_times.size() !== wr0) begin
            n_fail++;
            $display("FAIL reset_mid writes: got %0d expected 0", wr_times.size() - wr0);
        end
    endtask

    task automatic test_back_to_back;
        int wr0;
        wr0 = wr_times.size();
        run_instr("b2b_first", 3'b110, 2'b10, 3, 1, 1'b1, 1'b0);
        run_instr("b2b_second", 3'b110, 2'b10, 3, 1, 1'b1, 1'b0);
        s = 1'b0;
        n_tests++;
        if (wr_times.size() - wr0 !== 2) begin
            n_fail++;
            $display("FAIL b2b write_count: got %0d expected 2", wr_times.size() - wr0);
        end else begin
            n_tests++;
            if (wr_times[wr0 + 1] - wr_times[wr0] !== 3) begin
                n_fail++;
                $display("FAIL b2b write_spacing: got %0d expected 3",
                         wr_times[wr0 + 1] - wr_times[wr0]);
            end
        end
        check_idle_cycles("b2b_tail", 2);
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add_and();
        test_cmp_mvn();
        test_illegal();
        test_reset_mid_instr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
